// File: rtl/r5p_soc_uart.sv
// R5P SoC UART: memory-mapped slave with TX/RX byte FIFOs and a programmable
// baud divisor. Register map (byte offsets): 0x0 DATA, 0x4 STATUS,
// 0x8 DIVISOR, 0xC reserved (reads 0).
//
// TX FSM   | meaning
// ---------+--------------------------------------------------------
// TX_IDLE  | line high, pops the TX FIFO as soon as it is non-empty
// TX_START | driving the start bit (low) for DIVISOR+1 clocks
// TX_DATA  | shifting 8 data bits out LSB first
// TX_STOP  | driving the stop bit (high)
//
// RX FSM   | meaning
// ---------+--------------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | re-checks the line after DIVISOR>>1 clocks (glitch filter)
// RX_DATA  | sampling 8 data bits, one every DIVISOR+1 clocks
// RX_STOP  | sampling the stop bit, then pushes the byte or flags an error
module r5p_soc_uart #(
    parameter int          AW      = 4,
    parameter int          DW      = 32,
    parameter int          FD      = 4,
    parameter int          BDW     = 16,
    parameter int unsigned DIV_RST = 867
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bus_vld,
    input  logic            bus_wen,
    input  logic [AW-1:0]   bus_adr,
    input  logic [DW/8-1:0] bus_ben,
    input  logic [DW-1:0]   bus_wdt,
    output logic [DW-1:0]   bus_rdt,
    output logic            bus_rdy,
    output logic            uart_txd,
    input  logic            uart_rxd
);

    localparam int PW = $clog2(FD);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t      tx_state;
    rx_state_t      rx_state;

    logic [BDW-1:0] div;
    logic [DW-1:0]  ben_mask;
    logic [DW-1:0]  rdt_nxt;

    logic [PW:0]    tx_wp, tx_rp, rx_wp, rx_rp;
    logic [7:0]     tx_mem [FD];
    logic [7:0]     rx_mem [FD];
    logic           tx_empty, tx_full, rx_empty, rx_full, tx_idle;
    logic           tx_push, tx_pop, rx_push, rx_pop;

    logic [1:0]     reg_sel;
    logic           bus_wr, bus_rd;

    logic [BDW-1:0] tx_cnt, rx_cnt;
    logic [2:0]     tx_bit, rx_bit;
    logic [7:0]     tx_sh, rx_sh;

    logic [1:0]     rx_sync;
    logic           rx_s, rx_prev;
    logic           rx_good, rx_bad;
    logic           rx_ovr, rx_ferr, clr_ovr, clr_ferr;

    logic           unused_ok;

    assign bus_rdy = 1'b1;
    assign reg_sel = bus_adr[3:2];
    assign bus_wr  = bus_vld & bus_wen;
    assign bus_rd  = bus_vld & ~bus_wen;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[PW] != tx_rp[PW]) && (tx_wp[PW-1:0] == tx_rp[PW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[PW] != rx_rp[PW]) && (rx_wp[PW-1:0] == rx_rp[PW-1:0]);
    assign tx_idle  = tx_empty && (tx_state == TX_IDLE);

    // A push into a full FIFO is only legal when the same cycle pops it.
    assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;
    assign tx_push = bus_wr && (reg_sel == 2'd0) && bus_ben[0] && (!tx_full || tx_pop);
    assign rx_pop  = bus_rd && (reg_sel == 2'd0) && !rx_empty;
    assign rx_s    = rx_sync[1];
    assign rx_good = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s;
    assign rx_bad  = (rx_state == RX_STOP) && (rx_cnt == '0) && !rx_s;
    assign rx_push = rx_good && (!rx_full || rx_pop);

    assign clr_ovr  = bus_wr && (reg_sel == 2'd1) && bus_ben[0] && bus_wdt[3];
    assign clr_ferr = bus_wr && (reg_sel == 2'd1) && bus_ben[0] && bus_wdt[4];

    assign unused_ok = ^{bus_adr, bus_wdt, bus_ben, ben_mask};

    // Expand byte enables into a bit mask for the divisor write.
    always_comb begin
        ben_mask = '0;
        for (int b = 0; b < DW/8; b++) begin
            ben_mask[b*8 +: 8] = {8{bus_ben[b]}};
        end
    end

    // Read data mux; DATA shows the RX FIFO head, or 0 when empty.
    always_comb begin
        rdt_nxt = '0;
        case (reg_sel)
            2'd0: if (!rx_empty) rdt_nxt[7:0] = rx_mem[rx_rp[PW-1:0]];
            2'd1: rdt_nxt[4:0] = {rx_ferr, rx_ovr, rx_empty, tx_idle, tx_full};
            2'd2: rdt_nxt[BDW-1:0] = div;
            default: rdt_nxt = '0;
        endcase
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_rdt <= '0;
        else if (bus_rd) bus_rdt <= rdt_nxt;
    end

    // Divisor register and sticky RX error flags; a new error wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= BDW'(DIV_RST);
            rx_ovr  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            if (bus_wr && (reg_sel == 2'd2))
                div <= (div & ~ben_mask[BDW-1:0]) | (bus_wdt[BDW-1:0] & ben_mask[BDW-1:0]);
            if (rx_good && rx_full && !rx_pop) rx_ovr <= 1'b1;
            else if (clr_ovr)                  rx_ovr <= 1'b0;
            if (rx_bad)        rx_ferr <= 1'b1;
            else if (clr_ferr) rx_ferr <= 1'b0;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[PW-1:0]] <= bus_wdt[7:0];
        if (rx_push) rx_mem[rx_wp[PW-1:0]] <= rx_sh;
    end

    // Transmit FSM; txd is registered from the current state, giving one
    // extra cycle between the pop and the start bit on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_txd <= 1'b1;
                    if (!tx_empty) begin
                        tx_sh    <= tx_mem[tx_rp[PW-1:0]];
                        tx_cnt   <= div;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    uart_txd <= 1'b0;
                    if (tx_cnt == '0) begin
                        tx_cnt   <= div;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - BDW'(1);
                    end
                end
                TX_DATA: begin
                    uart_txd <= tx_sh[0];
                    if (tx_cnt == '0) begin
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_cnt <= div;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - BDW'(1);
                    end
                end
                TX_STOP: begin
                    uart_txd <= 1'b1;
                    if (tx_cnt == '0) tx_state <= TX_IDLE;
                    else              tx_cnt   <= tx_cnt - BDW'(1);
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rx_prev <= rx_s;
        end
    end

    // Receive FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt   <= div >> 1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= div;
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - BDW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_cnt <= div;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - BDW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) rx_state <= RX_IDLE;
                    else              rx_cnt   <= rx_cnt - BDW'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r5p_soc_uart.sv
// Bench for r5p_soc_uart: bus reads are scoreboarded, a serial monitor
// decodes uart_txd against the queue of bytes expected on the line.
module tb_r5p_soc_uart;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_vld = 1'b0;
    logic        bus_wen = 1'b0;
    logic [3:0]  bus_adr = '0;
    logic [3:0]  bus_ben = '0;
    logic [31:0] bus_wdt = '0;
    logic [31:0] bus_rdt;
    logic        bus_rdy;
    logic        uart_txd;
    logic        uart_rxd;
    logic        lb = 1'b0;
    logic        rxd_drv = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] exp;
        int          id;
    } rd_t;

    rd_t        rd_q[$];
    logic [7:0] tx_q[$];

    assign uart_rxd = lb ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    r5p_soc_uart dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_vld  (bus_vld),
        .bus_wen  (bus_wen),
        .bus_adr  (bus_adr),
        .bus_ben  (bus_ben),
        .bus_wdt  (bus_wdt),
        .bus_rdt  (bus_rdt),
        .bus_rdy  (bus_rdy),
        .uart_txd (uart_txd),
        .uart_rxd (uart_rxd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d, input logic [3:0] ben);
        @(negedge clk);
        bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = adr; bus_wdt = d; bus_ben = ben;
        @(posedge clk);
        #1;
        bus_vld = 1'b0; bus_wen = 1'b0;
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input int id);
        rd_q.push_back('{exp, id});
        @(negedge clk);
        bus_vld = 1'b1; bus_wen = 1'b0; bus_adr = adr; bus_ben = 4'hF;
        @(posedge clk);
        #1;
        bus_vld = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (4) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    // Read monitor: each read handshake pops one expectation.
    initial begin : rd_mon
        logic hs;
        rd_t  r;
        forever begin
            @(posedge clk);
            hs = bus_vld & ~bus_wen;
            #1;
            if (hs) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_unexpected: got 0x%0h with no expectation", bus_rdt);
                end else begin
                    r = rd_q.pop_front();
                    chk($sformatf("rd%0d", r.id), bus_rdt, r.exp);
                end
            end
        end
    end

    // Serial monitor on uart_txd, assuming 4 clocks per bit.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && uart_txd === 1'b0) begin
                repeat (2) @(posedge clk);
                #2;
                chk("tx_start_mid", {31'b0, uart_txd}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #2;
                    b[i] = uart_txd;
                end
                repeat (4) @(posedge clk);
                #2;
                chk("tx_stop_bit", {31'b0, uart_txd}, 32'h1);
                n_checks++;
                if (tx_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", b);
                end else if (b !== tx_q[0]) begin
                    n_errors++;
                    $display("FAIL tx_byte: got 0x%0h expected 0x%0h", b, tx_q[0]);
                    void'(tx_q.pop_front());
                end else begin
                    void'(tx_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] pat;
        logic       exp_bit;

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", {31'b0, uart_txd}, 32'h1);
        chk("rst_rdy", {31'b0, bus_rdy}, 32'h1);
        chk("rst_rdt", bus_rdt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        rd(4'h4, 32'h06, 1);
        rd(4'h8, 32'h363, 2);
        rd(4'h0, 32'h0, 3);
        rd(4'hC, 32'h0, 4);

        // Divisor byte enables, width truncation, reserved register.
        wr(4'h8, 32'h0000_AB00, 4'b0010);
        rd(4'h8, 32'hAB63, 5);
        wr(4'h8, 32'hFFFF_0003, 4'b1111);
        rd(4'h8, 32'h3, 6);
        wr(4'hC, 32'hFFFF_FFFF, 4'b1111);
        rd(4'hC, 32'h0, 7);
        rd(4'h4, 32'h06, 8);

        // Exact waveform of 0x55 with DIVISOR=3.
        pat = 8'h55;
        tx_q.push_back(pat);
        wr(4'h0, {24'b0, pat}, 4'b0001);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)       exp_bit = 1'b1;
            else if (k <= 5)  exp_bit = 1'b0;
            else if (k <= 37) exp_bit = pat[(k - 6) / 4];
            else              exp_bit = 1'b1;
            chk($sformatf("txd_wave_k%0d", k), {31'b0, uart_txd}, {31'b0, exp_bit});
        end
        rd(4'h4, 32'h06, 9);

        // Loopback of three bytes.
        lb = 1'b1;
        tx_q.push_back(8'hA3);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        wr(4'h0, 32'hA3, 4'b0001);
        wr(4'h0, 32'h00, 4'b0001);
        wr(4'h0, 32'hFF, 4'b0001);
        repeat (150) @(posedge clk);
        rd(4'h0, 32'hA3, 10);
        rd(4'h0, 32'h00, 11);
        rd(4'h0, 32'hFF, 12);
        rd(4'h0, 32'h00, 13);
        rd(4'h4, 32'h06, 14);

        // TX FIFO overflow: six back-to-back writes, the sixth is dropped.
        lb = 1'b0;
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        tx_q.push_back(8'h44);
        tx_q.push_back(8'h55);
        wr(4'h0, 32'h11, 4'b0001);
        wr(4'h0, 32'h22, 4'b0001);
        wr(4'h0, 32'h33, 4'b0001);
        wr(4'h0, 32'h44, 4'b0001);
        wr(4'h0, 32'h55, 4'b0001);
        wr(4'h0, 32'h66, 4'b0001);
        rd(4'h4, 32'h05, 15);
        repeat (240) @(posedge clk);
        rd(4'h4, 32'h06, 16);

        // RX FIFO overflow via loopback: five frames, four kept.
        lb = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tx_q.push_back(8'(i));
            wr(4'h0, 32'(i), 4'b0001);
        end
        repeat (240) @(posedge clk);
        rd(4'h4, 32'h0A, 17);
        rd(4'h0, 32'h01, 18);
        rd(4'h0, 32'h02, 19);
        rd(4'h0, 32'h03, 20);
        rd(4'h0, 32'h04, 21);
        rd(4'h4, 32'h0E, 22);
        wr(4'h4, 32'h08, 4'b0001);
        rd(4'h4, 32'h06, 23);
        lb = 1'b0;

        // One-clock glitch on rxd.
        @(negedge clk);
        rxd_drv = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(posedge clk);
        rd(4'h4, 32'h06, 24);

        // Framing error, then clear it, then a good frame.
        send_rx(8'h5A, 1'b0);
        repeat (20) @(posedge clk);
        rd(4'h4, 32'h16, 25);
        rd(4'h0, 32'h00, 26);
        wr(4'h4, 32'h10, 4'b0001);
        rd(4'h4, 32'h06, 27);
        send_rx(8'hC3, 1'b1);
        repeat (10) @(posedge clk);
        rd(4'h0, 32'hC3, 28);
        rd(4'h4, 32'h06, 29);

        repeat (5) @(posedge clk);
        chk("tx_frames_left", 32'(tx_q.size()), 32'h0);
        chk("rd_expect_left", 32'(rd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

endmodule
